rv32_ibus_responder: RTL and testbench

Instruction-bus responder serving the fetch stage's read port: returns `instr_read_value_out` and `instr_fault_out` for the fetch address, and requests a pipeline stall on a miss. It holds one line of `LINE_WORDS` instructions. Misses are filled from a slower backing memory over a req/ack word interface. It sits between `rv32_fetch` and the SoC memory fabric (flash/SDRAM controller), replacing a zero-wait instruction RAM.

---
 rtl/rv32_ibus_pkg.sv | 18 +
 rtl/rv32_ibus_line.sv | 79 +++++++
 rtl/rv32_ibus_responder.sv | 196 +++++++++++++++++++
 tb/tb_rv32_ibus_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ibus_pkg.sv
// -----------------------------------------------------------------------------
// rv32_ibus_pkg
// Shared types and constants for the rv32 instruction-bus responder:
//   - rv32_ibus_state_e : fill controller states (IDLE, FILL, ERR)
//   - RV32_IBUS_NOP     : instruction returned whenever no valid word exists
// -----------------------------------------------------------------------------
package rv32_ibus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        ERR  = 2'd2
    } rv32_ibus_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] RV32_IBUS_NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32_ibus_line.sv
// -----------------------------------------------------------------------------
// rv32_ibus_line
// Single-line instruction store: LINE_WORDS data words, one tag and a valid
// bit, with a combinational tag compare and word select for the fetch port.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset (valid/tag)
//   tag_load, tag_in        capture a new line tag
//   valid_clr, valid_set    invalidate / validate the line (clear wins)
//   word_we, word_idx,
//   word_data               write one word of the line
//   lookup_tag, lookup_idx  fetch address fields to look up
//   hit                     line valid and tag matches
//   lookup_word             stored word at lookup_idx
// -----------------------------------------------------------------------------
module rv32_ibus_line
    import rv32_ibus_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tag_load,
    input  logic [29-OFF_W:0] tag_in,
    input  logic              valid_clr,
    input  logic              valid_set,
    input  logic              word_we,
    input  logic [OFF_W-1:0]  word_idx,
    input  logic [31:0]       word_data,
    input  logic [29-OFF_W:0] lookup_tag,
    input  logic [OFF_W-1:0]  lookup_idx,
    output logic              hit,
    output logic [31:0]       lookup_word
);

    logic [29-OFF_W:0] tag_q, tag_d;
    logic              valid_q, valid_d;
    logic [31:0]       words_q [LINE_WORDS];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        tag_d   = tag_q;
        valid_d = valid_q;
        if (tag_load) begin
            tag_d = tag_in;
        end
        if (valid_clr) begin
            valid_d = 1'b0;
        end else if (valid_set) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!reset_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: the data array is deliberately not reset; the valid bit alone
    // guards it, which keeps it mappable onto plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (word_we) begin
            words_q[word_idx] <= word_data;
        end
    end

    assign hit         = valid_q && (tag_q == lookup_tag);
    assign lookup_word = words_q[lookup_idx];

endmodule

// File: rtl/rv32_ibus_responder.sv
// -----------------------------------------------------------------------------
// rv32_ibus_responder
// Instruction-bus responder for the fetch stage. Holds one line of LINE_WORDS
// instructions; hits and access faults answer combinationally, misses stall
// the pipeline while the line is filled word by word over a req/ack port.
//
// Configuration macro:
//   RV32_IBUS_WRAP_FILL_EN  defined: fill starts at the requested word and
//                           wraps (critical word first); undefined: fill
//                           always starts at word 0, ascending.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   instr_read_in              fetch read request
//   instr_address_in           fetch byte address
//   flush_in                   invalidate the line (fence.i)
//   instr_read_value_out       instruction word (NOP when none available)
//   instr_fault_out            access fault for the current address
//   instr_stall_out            pipeline stall request
//   mem_req_out, mem_addr_out  backing read request and word address
//   mem_ack_in, mem_rdata_in,
//   mem_err_in                 backing acknowledge, data and bus error
// -----------------------------------------------------------------------------
module rv32_ibus_responder
    import rv32_ibus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] SIZE_BYTES = 32'h0001_0000,
    parameter int          LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    input  logic        flush_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_fault_out,
    output logic        instr_stall_out,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in,
    input  logic        mem_err_in
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - OFF_W;

    rv32_ibus_state_e   state_q, state_d;
    logic               drop_q, drop_d;
    logic [OFF_W-1:0]   idx_q, idx_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;

    logic [TAG_W-1:0]   req_tag;
    logic [OFF_W-1:0]   req_off;
    logic [OFF_W-1:0]   start_idx;
    logic [OFF_W-1:0]   idx_nxt;
    logic               addr_fault;
    logic               miss;
    logic               line_hit;
    logic [31:0]        line_word;
    logic               tag_load, valid_clr, valid_set, word_we;

    assign req_tag = instr_address_in[31:OFF_W+2];
    assign req_off = instr_address_in[OFF_W+1:2];
    assign idx_nxt = idx_q + 1'b1;

`ifdef RV32_IBUS_WRAP_FILL_EN
    assign start_idx = req_off;
`else
    assign start_idx = '0;
`endif

    // The unsigned difference makes any address below BASE_ADDR wrap to a
    // huge offset; the explicit lower-bound compare is kept for clarity.
    assign addr_fault = (instr_address_in[1:0] != 2'b00)
                     || (instr_address_in < BASE_ADDR)
                     || ((instr_address_in - BASE_ADDR) >= SIZE_BYTES);

    assign miss = instr_read_in && !line_hit && !addr_fault;

    rv32_ibus_line #(
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W)
    ) u_line (
        .clk         (clk),
        .reset_n     (reset_n),
        .tag_load    (tag_load),
        .tag_in      (req_tag),
        .valid_clr   (valid_clr),
        .valid_set   (valid_set),
        .word_we     (word_we),
        .word_idx    (idx_q),
        .word_data   (mem_rdata_in),
        .lookup_tag  (req_tag),
        .lookup_idx  (req_off),
        .hit         (line_hit),
        .lookup_word (line_word)
    );

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        idx_d      = idx_q;
        beat_d     = beat_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        tag_load   = 1'b0;
        valid_clr  = 1'b0;
        valid_set  = 1'b0;
        word_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d    = FILL;
                    drop_d     = 1'b0;
                    tag_load   = 1'b1;
                    valid_clr  = 1'b1;
                    idx_d      = start_idx;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {req_tag, start_idx, 2'b00};
                end else if (flush_in) begin
                    valid_clr = 1'b1;
                end
            end

            FILL: begin
                if (flush_in) begin
                    drop_d = 1'b1;
                end
                if (mem_ack_in) begin
                    if (mem_err_in) begin
                        state_d   = ERR;
                        valid_clr = 1'b1;
                        mem_req_d = 1'b0;
                    end else begin
                        word_we = 1'b1;
                        if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                            // A flush landing on the final beat must also
                            // keep the freshly filled line invalid.
                            state_d   = IDLE;
                            drop_d    = 1'b0;
                            valid_set = !(drop_q || flush_in);
                            mem_req_d = 1'b0;
                        end else begin
                            idx_d      = idx_nxt;
                            beat_d     = beat_q + 1'b1;
                            mem_addr_d = {mem_addr_q[31:OFF_W+2], idx_nxt, 2'b00};
                        end
                    end
                end
            end

            ERR: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            drop_q     <= 1'b0;
            idx_q      <= '0;
            beat_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Fetch-side outputs are forced quiet while reset is asserted.
    assign instr_fault_out = reset_n && (addr_fault || (state_q == ERR));
    assign instr_stall_out = reset_n && ((state_q == FILL) || ((state_q == IDLE) && miss));
    assign instr_read_value_out =
        (reset_n && !addr_fault && (state_q == IDLE) && line_hit) ? line_word : RV32_IBUS_NOP;

    assign mem_req_out  = mem_req_q;
    assign mem_addr_out = mem_addr_q;

endmodule

// File: tb/tb_rv32_ibus_responder.sv
// -----------------------------------------------------------------------------
// tb_rv32_ibus_responder
// Self-checking bench: directed scenarios followed by randomized fetch traffic
// against a transaction-level model of the single-line store, with a backing
// memory responder that returns (address ^ key) after a configurable wait.
// -----------------------------------------------------------------------------
module tb_rv32_ibus_responder;

    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam logic [31:0] SIZE       = 32'h0001_0000;
    localparam int          LW         = 4;
    localparam logic [31:0] LINE_BYTES = LW * 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic        flush_in;
    logic [31:0] instr_read_value_out;
    logic        instr_fault_out;
    logic        instr_stall_out;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;
    logic        mem_err_in;

    rv32_ibus_responder #(
        .BASE_ADDR  (BASE),
        .SIZE_BYTES (SIZE),
        .LINE_WORDS (LW)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .flush_in             (flush_in),
        .instr_read_value_out (instr_read_value_out),
        .instr_fault_out      (instr_fault_out),
        .instr_stall_out      (instr_stall_out),
        .mem_req_out          (mem_req_out),
        .mem_addr_out         (mem_addr_out),
        .mem_ack_in           (mem_ack_in),
        .mem_rdata_in         (mem_rdata_in),
        .mem_err_in           (mem_err_in)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          mem_wait = 0;
    int          err_beat = -1;
    logic [31:0] key = 32'h0;
    logic [31:0] obs_q[$];

    // Reference line model
    bit          m_valid = 1'b0;
    logic [31:0] m_base  = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ key;
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a < BASE) || (a - BASE >= SIZE);
    endfunction

    // Backing memory: ack after mem_wait idle cycles per word, optional error.
    initial begin
        int          beat;
        int          waited;
        logic [31:0] hold_addr;
        beat = 0; waited = 0; hold_addr = '0;
        mem_ack_in = 1'b0; mem_err_in = 1'b0; mem_rdata_in = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack_in = 1'b0; mem_err_in = 1'b0; mem_rdata_in = '0;
            if (!reset_n || !mem_req_out) begin
                beat = 0; waited = 0;
            end else begin
                if (waited == 0) hold_addr = mem_addr_out;
                else check("addr_stable", mem_addr_out, hold_addr);
                if (waited < mem_wait) begin
                    waited++;
                end else begin
                    mem_ack_in   = 1'b1;
                    mem_rdata_in = mem_word(mem_addr_out);
                    mem_err_in   = (beat == err_beat);
                    obs_q.push_back(mem_addr_out);
                    beat++;
                    waited = 0;
                end
            end
        end
    end

    // One fetch transaction; err_at >= 0 errors that beat, flush_at >= 2
    // pulses flush in that stall sample (always inside the fill).
    task automatic fetch(input logic [31:0] a, input int err_at, input int flush_at);
        logic [31:0] lb;
        logic [31:0] exp_q[$];
        bit          flt, hit, err;
        int          fills, nwords, start, exp_stall, stall_cnt;
        lb    = a & ~(LINE_BYTES - 1);
        flt   = is_fault(a);
        hit   = !flt && m_valid && (m_base == lb);
        err   = !flt && !hit && (err_at >= 0);
        fills = (flt || hit) ? 0 : (!err && flush_at > 0) ? 2 : 1;
`ifdef RV32_IBUS_WRAP_FILL_EN
        start = int'((a - lb) / 4);
`else
        start = 0;
`endif
        for (int f = 0; f < fills; f++) begin
            nwords = err ? err_at + 1 : LW;
            for (int i = 0; i < nwords; i++) exp_q.push_back(lb + 32'(((start + i) % LW) * 4));
        end
        if (flt || hit) exp_stall = 0;
        else if (err)   exp_stall = 1 + (err_at + 1) * (mem_wait + 1);
        else            exp_stall = fills * (1 + LW * (mem_wait + 1));

        @(posedge clk); #2;
        obs_q.delete();
        err_beat         = err ? err_at : -1;
        instr_address_in = a;
        instr_read_in    = 1'b1;
        stall_cnt        = 0;
        forever begin
            @(negedge clk);
            if (!instr_stall_out) break;
            if (stall_cnt == 0) begin
                check("stall_value_nop", instr_read_value_out, NOP);
                check("stall_fault", 32'(instr_fault_out), 32'd0);
            end
            stall_cnt++;
            if (stall_cnt > 300) begin
                check("stall_timeout", 32'(stall_cnt), 32'(exp_stall));
                break;
            end
            if (flush_at > 0 && stall_cnt == flush_at) begin
                flush_in = 1'b1;
                @(posedge clk); #2;
                flush_in = 1'b0;
            end
        end
        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        if (flt || err) begin
            check("fault", 32'(instr_fault_out), 32'd1);
            check("fault_value", instr_read_value_out, NOP);
        end else begin
            check("fault", 32'(instr_fault_out), 32'd0);
            check("value", instr_read_value_out, mem_word(a));
        end
        check("fill_len", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("fill_addr", obs_q[i], exp_q[i]);

        if (err)       m_valid = 1'b0;
        else if (!flt) begin m_valid = 1'b1; m_base = lb; end

        @(posedge clk); #2;
        instr_read_in = 1'b0;
        err_beat      = -1;
        @(negedge clk);
        check("req_idle_after", 32'(mem_req_out), 32'd0);
    endtask

    task automatic idle_op(input logic [31:0] a);
        @(posedge clk); #2;
        instr_address_in = a;
        instr_read_in    = 1'b0;
        @(negedge clk);
        check("noread_stall", 32'(instr_stall_out), 32'd0);
        @(negedge clk);
        check("noread_req", 32'(mem_req_out), 32'd0);
    endtask

    task automatic flush_idle();
        @(posedge clk); #2;
        instr_read_in = 1'b0;
        flush_in      = 1'b1;
        @(posedge clk); #2;
        flush_in = 1'b0;
        m_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] lines [4];
        logic [31:0] a;
        int          r, s, ea, fa;
        lines[0] = 32'h0000_0000; lines[1] = 32'h0000_0040;
        lines[2] = 32'h0000_1230; lines[3] = 32'h0000_FFF0;

        reset_n = 1'b0; instr_read_in = 1'b1; instr_address_in = 32'h2; flush_in = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(instr_stall_out), 32'd0);
        check("rst_fault", 32'(instr_fault_out), 32'd0);
        check("rst_value", instr_read_value_out, NOP);
        check("rst_req", 32'(mem_req_out), 32'd0);
        check("rst_addr", mem_addr_out, 32'd0);
        @(posedge clk); #2;
        instr_read_in = 1'b0;
        reset_n = 1'b1;

        // Directed scenarios with address-as-data memory
        fetch(32'h0, -1, 0);
        fetch(32'h8, -1, 0);
        fetch(32'h2, -1, 0);
        fetch(32'h0001_0000, -1, 0);
        flush_idle();
        fetch(32'h0, 1, 0);
        fetch(32'h0, -1, 0);
        fetch(32'h40, -1, 3);
        fetch(32'h44, -1, 0);
        mem_wait = 3;
        fetch(32'h84, -1, 0);
        mem_wait = 0;
        fetch(32'h28, -1, 0);
        fetch(32'h20, -1, 0);

        // Asynchronous reset in the middle of a fill
        @(posedge clk); #2;
        instr_address_in = 32'h100; instr_read_in = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_stall", 32'(instr_stall_out), 32'd0);
        check("midrst_req", 32'(mem_req_out), 32'd0);
        check("midrst_addr", mem_addr_out, 32'd0);
        check("midrst_value", instr_read_value_out, NOP);
        @(posedge clk); #2;
        instr_read_in = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        m_valid = 1'b0;
        fetch(32'h28, -1, 0);

        // Randomized traffic
        key = $urandom;
        flush_idle();
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: fetch(((32'($urandom_range(0, 16383))) << 2) | 32'($urandom_range(1, 3)), -1, 0);
                1: fetch(($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC
                         : SIZE + ((32'($urandom_range(0, 1023))) << 2), -1, 0);
                2: idle_op(lines[$urandom_range(0, 3)] + 32'($urandom_range(0, LW - 1) * 4));
                3: flush_idle();
                default: begin
                    a        = lines[$urandom_range(0, 3)] + 32'($urandom_range(0, LW - 1) * 4);
                    mem_wait = $urandom_range(0, 3);
                    s        = $urandom_range(0, 9);
                    ea       = (s == 0) ? $urandom_range(0, LW - 1) : -1;
                    fa       = (s == 1) ? $urandom_range(2, LW * (mem_wait + 1) + 1) : 0;
                    fetch(a, ea, fa);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
